// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller.
// Walks a GHASH job through key load, S clear, the AAD blocks, the ciphertext
// blocks and the final length block, driving the datapath register enables and
// the input mux. Every output except ac_reg_en is registered from the next state.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; all outputs low
// H_LOAD  | load hash key H, clear accumulator
// S_CLR   | S <= H*0, i.e. S = 0
// AAD_ACC | accumulate one AAD block when blk_valid
// AAD_MUL | S <= H*acc for the AAD block just accumulated
// CT_ACC  | accumulate one ciphertext block when blk_valid
// CT_MUL  | S <= H*acc for the ciphertext block just accumulated
// LEN_ACC | accumulate the length block when blk_valid
// LEN_MUL | S <= H*acc, producing the tag
// DONE    | one-cycle done pulse; S holds the final tag

module ghash_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_aad,
    input  logic [CNT_W-1:0] num_ct,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic             h_reg_en,
    output logic [1:0]       mux_sel,
    output logic             ac_reg_en,
    output logic             ac_clr,
    output logic             s_reg_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        H_LOAD  = 4'd1,
        S_CLR   = 4'd2,
        AAD_ACC = 4'd3,
        AAD_MUL = 4'd4,
        CT_ACC  = 4'd5,
        CT_MUL  = 4'd6,
        LEN_ACC = 4'd7,
        LEN_MUL = 4'd8,
        DONE    = 4'd9
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       blk_ready;
        logic       h_reg_en;
        logic       ac_clr;
        logic       s_reg_en;
        logic [1:0] mux_sel;
    } out_t;

    localparam logic [1:0] SEL_AAD = 2'b00;
    localparam logic [1:0] SEL_CT  = 2'b01;
    localparam logic [1:0] SEL_LEN = 2'b10;

    state_t           state;
    state_t           nxt;
    out_t             outs;
    logic [CNT_W-1:0] aad_cnt;
    logic [CNT_W-1:0] ct_cnt;

    // Moore output decode for a given state.
    function automatic out_t decode(state_t s);
        out_t o;
        o = '0;
        case (s)
            IDLE:    o = '0;
            H_LOAD:  begin o.busy = 1'b1; o.h_reg_en = 1'b1; o.ac_clr = 1'b1; end
            S_CLR:   begin o.busy = 1'b1; o.s_reg_en = 1'b1; end
            AAD_ACC: begin o.busy = 1'b1; o.blk_ready = 1'b1; o.mux_sel = SEL_AAD; end
            AAD_MUL: begin o.busy = 1'b1; o.s_reg_en = 1'b1; o.mux_sel = SEL_AAD; end
            CT_ACC:  begin o.busy = 1'b1; o.blk_ready = 1'b1; o.mux_sel = SEL_CT; end
            CT_MUL:  begin o.busy = 1'b1; o.s_reg_en = 1'b1; o.mux_sel = SEL_CT; end
            LEN_ACC: begin o.busy = 1'b1; o.blk_ready = 1'b1; o.mux_sel = SEL_LEN; end
            LEN_MUL: begin o.busy = 1'b1; o.s_reg_en = 1'b1; o.mux_sel = SEL_LEN; end
            DONE:    begin o.busy = 1'b1; o.done = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Next-state logic; a zero count skips its phase entirely.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = H_LOAD;
            H_LOAD:  nxt = S_CLR;
            S_CLR: begin
                if (aad_cnt != '0)     nxt = AAD_ACC;
                else if (ct_cnt != '0) nxt = CT_ACC;
                else                   nxt = LEN_ACC;
            end
            AAD_ACC: if (blk_valid) nxt = AAD_MUL;
            AAD_MUL: begin
                // aad_cnt still holds the pre-decrement value here
                if (aad_cnt != CNT_W'(1)) nxt = AAD_ACC;
                else if (ct_cnt != '0)    nxt = CT_ACC;
                else                      nxt = LEN_ACC;
            end
            CT_ACC:  if (blk_valid) nxt = CT_MUL;
            CT_MUL: begin
                if (ct_cnt != CNT_W'(1)) nxt = CT_ACC;
                else                     nxt = LEN_ACC;
            end
            LEN_ACC: if (blk_valid) nxt = LEN_MUL;
            LEN_MUL: nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, registered outputs and remaining-block counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            outs    <= '0;
            aad_cnt <= '0;
            ct_cnt  <= '0;
        end else begin
            state <= nxt;
            outs  <= decode(nxt);
            case (state)
                IDLE: begin
                    if (start) begin
                        aad_cnt <= num_aad;
                        ct_cnt  <= num_ct;
                    end
                end
                // only reached with a nonzero count, so these never wrap
                AAD_MUL: aad_cnt <= aad_cnt - CNT_W'(1);
                CT_MUL:  ct_cnt  <= ct_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign busy      = outs.busy;
    assign done      = outs.done;
    assign blk_ready = outs.blk_ready;
    assign h_reg_en  = outs.h_reg_en;
    assign ac_clr    = outs.ac_clr;
    assign s_reg_en  = outs.s_reg_en;
    assign mux_sel   = outs.mux_sel;
    // a block is taken in exactly the cycles where it is offered and accepted
    assign ac_reg_en = outs.blk_ready & blk_valid;

endmodule
